mem_stage_stall: RTL
====================

# mem_stage_stall

Parametrised memory stage for the pipelined CPU. It replaces the single-cycle data memory access with a multi-cycle, stall-generating access to an internal word array. It adds alignment checking and a halt state that is sticky until reset. It sits between execute and writeback, and its `stall` output freezes the pipeline registers upstream of it while an access is in flight.

## Interface
Parameters:
- `DATA_W`, 16: data word width in bits; a multiple of 8 and a power of two.
- `ADDR_W`, 16: byte address width.
- `DEPTH`, 256: number of words in the internal array; a power of two.
- `LATENCY`, 2: number of BUSY cycles per access; must be at least 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `memRead`  in  1  read request.
- `memWrite`  in  1  write request.
- `aluOut`  in  ADDR_W  byte address.
- `writeData`  in  DATA_W  store data.
- `halt`  in  1  halt instruction has reached this stage.
- `readData`  out  DATA_W  last read result (registered).
- `done`  out  1  one-cycle pulse when an access completes.
- `align_err`  out  1  the completing access was misaligned; valid only when `done`=1.
- `stall`  out  1  hold the upstream pipeline.
- `halted`  out  1  the stage is halted.

## Operation
- Address mapping:
  - `OFF` = log2(DATA_W/8).
  - Word index = `aluOut[OFF +: log2(DEPTH)]`; upper address bits are ignored.
  - An access is misaligned if `aluOut[OFF-1:0]` is not 0. For DATA_W=16 this is `aluOut[0]`. When DATA_W=8 there is no alignment check.
- A request is present when `memRead | memWrite` is 1. If both are 1, the access is a write and `readData` is not updated.
- State machine with states IDLE, BUSY, DONE, HALTED. Reset state is IDLE.
- IDLE transitions:
  - `halt`=1 → HALTED. `halt` takes priority over any request presented in the same cycle, and that request is dropped.
  - Aligned request present → BUSY. Capture op, word index, writeData; load the counter with `LATENCY`-1.
  - Misaligned request present → DONE with `align_err` set. No array access occurs.
  - Otherwise stay in IDLE.
- BUSY:
  - Decrement the counter each cycle.
  - On the cycle the counter is 0, the transition edge does the access:
    - write: `mem[idx] <= data`;
    - read: `readData <= mem[idx]`.
  - Then go to DONE.
- DONE:
  - `done`=1, `stall`=0.
  - Inputs are ignored, because they still belong to the completing instruction.
  - Next state is IDLE.
- HALTED: absorbing; all requests are ignored. Only `rst` leaves it.
- A `halt` that arrives while the stage is in BUSY or DONE has no effect until IDLE. The in-flight access always completes first.
- Outputs:
  - `stall` = (state==BUSY) | (state==IDLE & request present & ~halt).
  - `done` = (state==DONE).
  - `align_err` is a register that is set on IDLE→DONE when the request is misaligned and cleared on DONE exit.
  - `halted` = (state==HALTED).
- Reset:
  - Clears every array word to 0, `readData` to 0, `align_err` to 0, and the counter to 0. State goes to IDLE.
  - Reset during BUSY abandons the access: no write occurs and `readData` stays 0.

## Timing
- The request is presented in cycle 0.
- Aligned access:
  - `stall`=1 in cycles 0..LATENCY.
  - The array is updated at the end of cycle LATENCY.
  - `done`=1 in cycle LATENCY+1, and `readData` is valid from cycle LATENCY+1 until the next read completes.
  - Total: LATENCY+2 cycles from request to the next request accepted in IDLE.
- Misaligned access:
  - `stall`=1 in cycle 0.
  - `done`=1 and `align_err`=1 in cycle 1.
  - Back in IDLE in cycle 2.
- Back-to-back accesses: the upstream pipeline advances at the end of the DONE cycle, so the next instruction's request is seen in IDLE one cycle later. No request is lost or duplicated.
- `halt` in IDLE: `halted`=1 from the next cycle, and `stall` stays 0 in the halt cycle.

## Test plan
1. Reset, then read. With LATENCY=2, DEPTH=256: after `rst`, read `aluOut`=0x0010 → `stall`=1 in cycles 0-2, `done`=1 in cycle 3, `readData`=0x0000.
2. Write then read. Write 0xBEEF to 0x0020 → `done` in cycle 3. Wait one IDLE cycle, then read 0x0020 → `readData`=0xBEEF with `done` in the read's cycle 3, and `align_err`=0.
3. Misaligned access. Write 0x1234 to 0x0021 → `stall`=1 in cycle 0 only, and `done`=`align_err`=1 in cycle 1. A subsequent read of 0x0020 returns the earlier 0xBEEF, so no array write occurred.
4. Halt priority and stickiness:
   - `halt`=1 together with `memWrite` to 0x0030 in IDLE → `halted`=1 next cycle and `stall`=0. A later read request produces no `stall` and no `done`.
   - After `rst`, reading 0x0030 returns 0.
   - Separately, `halt` asserted during BUSY → the access completes (`done` pulses), then the stage enters HALTED.
5. Reset mid-access. `rst` pulsed in cycle 1 of a write of 0xAAAA to 0x0040 → state IDLE with all outputs 0 the next cycle. A later read of 0x0040 returns 0x0000.
6. Parameter sweep:
   - LATENCY=1 and LATENCY=5 → `stall` width is LATENCY+1 cycles and `done` arrives in cycle LATENCY+1.
   - DATA_W=32 → addresses with `aluOut[1:0]`≠0 raise `align_err`.
   - Both simultaneous-request cases behave as writes: `memRead`=`memWrite`=1 writes the word and leaves `readData` unchanged.

Source files
------------

// File: rtl/mem_stage_stall.sv
// mem_stage_stall: multi-cycle memory stage for the pipelined CPU.
// A request is held in the stage for LATENCY busy cycles. The stage stalls
// the upstream pipeline during that time and then pulses done for one cycle.
// Misaligned requests complete at once with align_err set and do not touch
// the array. A halt seen in IDLE parks the stage in HALTED until reset.
module mem_stage_stall #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] aluOut,
    input  logic [DATA_W-1:0] writeData,
    input  logic              halt,
    output logic [DATA_W-1:0] readData,
    output logic              done,
    output logic              align_err,
    output logic              stall,
    output logic              halted
);

    // Byte offset bits inside a word; zero for byte-wide words, so the mask is empty
    localparam int OFF = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        DONE   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt;
    logic              op_write;
    logic [IDX_W-1:0]  op_idx;
    logic [DATA_W-1:0] op_data;
    logic              align_err_q;

    logic              request;
    logic              misaligned;
    logic [IDX_W-1:0]  req_idx;

    assign request    = memRead | memWrite;
    assign misaligned = |(aluOut & OFF_MASK);
    assign req_idx    = aluOut[OFF +: IDX_W];

    // State register; reset always returns to IDLE and abandons any access
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and stall decode; halt in IDLE wins over a request in the same cycle
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (halt) begin
                    next_state = HALTED;
                end else if (request) begin
                    stall = 1'b1;
                    if (misaligned) begin
                        next_state = DONE;
                    end else begin
                        next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: capture the request, count down the busy cycles, perform the array access
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            readData    <= '0;
            align_err_q <= 1'b0;
            cnt         <= '0;
            op_write    <= 1'b0;
            op_idx      <= '0;
            op_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!halt && request) begin
                        if (misaligned) begin
                            align_err_q <= 1'b1;
                        end else begin
                            op_write <= memWrite;
                            op_idx   <= req_idx;
                            op_data  <= writeData;
                            cnt      <= CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        if (op_write) begin
                            mem[op_idx] <= op_data;
                        end else begin
                            readData <= mem[op_idx];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    align_err_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign done      = (state == DONE);
    assign halted    = (state == HALTED);
    assign align_err = align_err_q;

endmodule
